// File: rtl/mem_port_arbiter_if.sv
// Bundle of the arbiter's cache-side and memory-bus signals.
// master = the arbiter itself, slave = the caches plus memory bus model.
interface mem_port_arbiter_if #(
   parameter int LW_BITS = 2
);
   logic                ic_req;
   logic [31:0]         ic_addr;
   logic                ic_busy;
   logic                ic_rvalid;
   logic [31:0]         ic_rdata;
   logic [LW_BITS-1:0]  ic_beat;
   logic                ic_done;

   logic                dc_req;
   logic                dc_we;
   logic [31:0]         dc_addr;
   logic [31:0]         dc_wdata;
   logic                dc_busy;
   logic                dc_rvalid;
   logic [31:0]         dc_rdata;
   logic [LW_BITS-1:0]  dc_beat;
   logic                dc_done;

   logic                mem_req;
   logic                mem_we;
   logic [31:0]         mem_addr;
   logic [31:0]         mem_wdata;
   logic                mem_ready;
   logic [31:0]         mem_rdata;

   modport master (
      input  ic_req, ic_addr, dc_req, dc_we, dc_addr, dc_wdata, mem_ready, mem_rdata,
      output ic_busy, ic_rvalid, ic_rdata, ic_beat, ic_done,
      output dc_busy, dc_rvalid, dc_rdata, dc_beat, dc_done,
      output mem_req, mem_we, mem_addr, mem_wdata
   );

   modport slave (
      output ic_req, ic_addr, dc_req, dc_we, dc_addr, dc_wdata, mem_ready, mem_rdata,
      input  ic_busy, ic_rvalid, ic_rdata, ic_beat, ic_done,
      input  dc_busy, dc_rvalid, dc_rdata, dc_beat, dc_done,
      input  mem_req, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin owner of the main-memory port: I-cache fills vs D-cache fills/writebacks,
// each grant a fixed in-order burst of LINE_WORDS beats followed by a one-cycle done pulse.
module mem_port_arbiter #(
   parameter int LINE_WORDS = 4,
   parameter int LW_BITS    = 2
) (
   input  logic                CLK,
   input  logic                RESET,
   mem_port_arbiter_if.master  bus,
   output logic [1:0]          dbg_state
);

   typedef enum logic [1:0] {IDLE = 2'd0, I_XFER = 2'd1, D_XFER = 2'd2, DONE = 2'd3} state_e;

   localparam logic [31:0]        LINE_MASK = ~(32'(LINE_WORDS * 4) - 32'd1);
   localparam logic [LW_BITS-1:0] LAST_BEAT = LW_BITS'(LINE_WORDS - 1);

   state_e               state_q, state_d;
   logic [LW_BITS-1:0]   beat_q, beat_d;
   logic [31:0]          base_q, base_d;
   logic                 we_q, we_d;
   logic                 last_d_q, last_d_d;   // 1 = D side won the most recent grant

   logic xfer, in_done, i_owner, d_owner;

   // Bus handshake: a beat completes in any XFER cycle where mem_ready is high;
   // mem_req/mem_addr/mem_we stay stable while mem_ready is low.
   always_comb begin
      state_d  = state_q;
      beat_d   = beat_q;
      base_d   = base_q;
      we_d     = we_q;
      last_d_d = last_d_q;
      case (state_q)
         IDLE: begin
            if (bus.ic_req && (!bus.dc_req || last_d_q)) begin
               state_d  = I_XFER;
               base_d   = bus.ic_addr & LINE_MASK;
               we_d     = 1'b0;
               beat_d   = '0;
               last_d_d = 1'b0;
            end else if (bus.dc_req) begin
               state_d  = D_XFER;
               base_d   = bus.dc_addr & LINE_MASK;
               we_d     = bus.dc_we;
               beat_d   = '0;
               last_d_d = 1'b1;
            end
         end
         I_XFER, D_XFER: begin
            if (bus.mem_ready) begin
               beat_d = beat_q + LW_BITS'(1);
               if (beat_q == LAST_BEAT) state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_q  <= IDLE;
         beat_q   <= '0;
         base_q   <= '0;
         we_q     <= 1'b0;
         last_d_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         beat_q   <= beat_d;
         base_q   <= base_d;
         we_q     <= we_d;
         last_d_q <= last_d_d;
      end
   end

   assign xfer    = (state_q == I_XFER) || (state_q == D_XFER);
   assign in_done = (state_q == DONE);
   assign i_owner = (xfer || in_done) && !last_d_q;
   assign d_owner = (xfer || in_done) &&  last_d_q;

   assign bus.mem_req   = xfer;
   assign bus.mem_we    = (state_q == D_XFER) && we_q;
   assign bus.mem_addr  = xfer ? (base_q | 32'({beat_q, 2'b00})) : 32'd0;
   assign bus.mem_wdata = bus.dc_wdata;

   assign bus.ic_rvalid = (state_q == I_XFER) && bus.mem_ready;
   assign bus.ic_rdata  = bus.ic_rvalid ? bus.mem_rdata : 32'd0;
   assign bus.ic_beat   = (state_q == I_XFER) ? beat_q : '0;
   assign bus.ic_done   = in_done && !last_d_q;

   assign bus.dc_rvalid = (state_q == D_XFER) && !we_q && bus.mem_ready;
   assign bus.dc_rdata  = bus.dc_rvalid ? bus.mem_rdata : 32'd0;
   assign bus.dc_beat   = (state_q == D_XFER) ? beat_q : '0;
   assign bus.dc_done   = in_done && last_d_q;

   // Busy is forced low in reset so the caches see the abandoned burst immediately.
   assign bus.ic_busy = RESET && (bus.ic_req || i_owner);
   assign bus.dc_busy = RESET && (bus.dc_req || d_owner);

   assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: expected beats are queued when a request is
// driven and checked against each accepted bus beat.
module tb_mem_port_arbiter;

   localparam int          LW     = 4;
   localparam int          LB     = 2;
   localparam logic [31:0] RD_KEY = 32'hA5A5_0000;

   logic        CLK = 1'b0;
   logic        RESET;
   logic [1:0]  dbg_state;

   int          n_vec = 0;
   int          n_err = 0;
   logic [65:0] exp_q[$];   // {side(1=D), we, addr, data}
   int          wait_states = 0;
   int          ws_cnt = 0;
   int          xfer_cnt = 0;
   logic [31:0] wbase = 32'h1234_0000;

   always #5 CLK = ~CLK;

   mem_port_arbiter_if #(.LW_BITS(LB)) bus ();

   mem_port_arbiter #(.LINE_WORDS(LW), .LW_BITS(LB)) dut (
      .CLK       (CLK),
      .RESET     (RESET),
      .bus       (bus.master),
      .dbg_state (dbg_state)
   );

   // Cache and memory models.
   assign bus.dc_wdata  = wbase + 32'(bus.dc_beat) * 32'h11;
   assign bus.mem_rdata = bus.mem_addr ^ RD_KEY;

   always @(negedge CLK) begin
      if (wait_states == 0) begin
         bus.mem_ready = 1'b1;
      end else if (bus.mem_req) begin
         if (ws_cnt == wait_states) begin
            bus.mem_ready = 1'b1;
            ws_cnt = 0;
         end else begin
            bus.mem_ready = 1'b0;
            ws_cnt++;
         end
      end else begin
         bus.mem_ready = 1'b0;
         ws_cnt = 0;
      end
   end

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Monitor: compares every accepted beat against the head of the scoreboard.
   always @(negedge CLK) begin
      logic [65:0] e;
      logic [31:0] a;
      logic [31:0] idx;
      #2;
      if (RESET && bus.mem_req) begin
         xfer_cnt++;
         if (exp_q.size() == 0) begin
            check_val("sb_underflow", 32'(exp_q.size()), 32'd1);
         end else if (!bus.mem_ready) begin
            a = exp_q[0][63:32];
            check_val("addr_hold", bus.mem_addr, a);
         end else begin
            e   = exp_q.pop_front();
            a   = e[63:32];
            idx = 32'(a[LB+1:2]);
            check_val("mem_addr", bus.mem_addr, a);
            check_val("mem_we", 32'(bus.mem_we), 32'(e[64]));
            if (!e[65]) begin
               check_val("ic_rvalid", 32'(bus.ic_rvalid), 32'd1);
               check_val("ic_rdata", bus.ic_rdata, e[31:0]);
               check_val("ic_beat", 32'(bus.ic_beat), idx);
               check_val("dc_rvalid_on_i", 32'(bus.dc_rvalid), 32'd0);
            end else if (!e[64]) begin
               check_val("dc_rvalid", 32'(bus.dc_rvalid), 32'd1);
               check_val("dc_rdata", bus.dc_rdata, e[31:0]);
               check_val("dc_beat", 32'(bus.dc_beat), idx);
               check_val("ic_rvalid_on_d", 32'(bus.ic_rvalid), 32'd0);
            end else begin
               check_val("mem_wdata", bus.mem_wdata, e[31:0]);
               check_val("dc_rvalid_on_wb", 32'(bus.dc_rvalid), 32'd0);
               check_val("dc_beat_wb", 32'(bus.dc_beat), idx);
            end
         end
      end
   end

   task automatic push_line(input bit side, input bit we, input logic [31:0] addr);
      logic [31:0] base, a, d;
      base = addr & ~32'(LW * 4 - 1);
      for (int i = 0; i < LW; i++) begin
         a = base | 32'(i * 4);
         d = we ? (wbase + 32'(i) * 32'h11) : (a ^ RD_KEY);
         exp_q.push_back({side, we, a, d});
      end
   endtask

   // Waits for the side's done pulse, drops its request in that cycle and
   // scrambles the side's address/we once its burst is underway.
   task automatic wait_done(input bit side, output int cycles);
      bit done;
      done   = 1'b0;
      cycles = 0;
      while (!done && cycles < 200) begin
         @(negedge CLK);
         cycles++;
         if (!side && bus.ic_done) begin
            done = 1'b1;
            bus.ic_req = 1'b0;
         end else if (side && bus.dc_done) begin
            done = 1'b1;
            bus.dc_req = 1'b0;
         end else if (!side && bus.ic_beat != '0) begin
            bus.ic_addr = $urandom;
         end else if (side && bus.dc_beat != '0) begin
            bus.dc_addr = $urandom;
            bus.dc_we   = 1'($urandom_range(0, 1));
         end
      end
      check_val(side ? "dc_done_seen" : "ic_done_seen", 32'(done), 32'd1);
   endtask

   task automatic start_req(input bit side, input bit we, input logic [31:0] addr);
      if (!side) begin
         bus.ic_addr = addr;
         bus.ic_req  = 1'b1;
      end else begin
         bus.dc_addr = addr;
         bus.dc_we   = we;
         bus.dc_req  = 1'b1;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int  c;
      bit  ok;
      bit  any_done;
      RESET       = 1'b0;
      bus.ic_req  = 1'b0;
      bus.ic_addr = '0;
      bus.dc_req  = 1'b0;
      bus.dc_we   = 1'b0;
      bus.dc_addr = '0;

      // Reset state.
      #2;
      check_val("rst_state", 32'(dbg_state), 32'd0);
      check_val("rst_mem_req", 32'(bus.mem_req), 32'd0);
      check_val("rst_mem_addr", bus.mem_addr, 32'd0);
      check_val("rst_ic_busy", 32'(bus.ic_busy), 32'd0);
      check_val("rst_dc_busy", 32'(bus.dc_busy), 32'd0);
      check_val("rst_ic_beat", 32'(bus.ic_beat), 32'd0);
      check_val("rst_mem_wdata", bus.mem_wdata, 32'h1234_0000);
      repeat (2) @(negedge CLK);
      RESET = 1'b1;
      wbase = 32'd0;

      // I fill alone, ready always high.
      push_line(1'b0, 1'b0, 32'hBFC0_001C);
      @(negedge CLK);
      start_req(1'b0, 1'b0, 32'hBFC0_001C);
      xfer_cnt = 0;
      wait_done(1'b0, c);
      check_val("i_fill_latency", 32'(c), 32'(LW + 1));
      check_val("i_fill_xfer_cycles", 32'(xfer_cnt), 32'(LW));
      check_val("sb_drained_1", 32'(exp_q.size()), 32'd0);

      // Two ties: D wins first, then I, then D again.
      for (int t = 0; t < 2; t++) begin
         push_line(1'b1, 1'b0, 32'h0000_2000 + 32'(t) * 32'h100);
         push_line(1'b0, 1'b0, 32'h0000_3004 + 32'(t) * 32'h100);
         @(negedge CLK);
         start_req(1'b1, 1'b0, 32'h0000_2000 + 32'(t) * 32'h100);
         start_req(1'b0, 1'b0, 32'h0000_3004 + 32'(t) * 32'h100);
         wait_done(1'b1, c);
         wait_done(1'b0, c);
         check_val("sb_drained_tie", 32'(exp_q.size()), 32'd0);
      end

      // Writeback.
      push_line(1'b1, 1'b1, 32'h8000_0040);
      @(negedge CLK);
      start_req(1'b1, 1'b1, 32'h8000_0040);
      wait_done(1'b1, c);
      bus.dc_we = 1'b0;
      check_val("sb_drained_wb", 32'(exp_q.size()), 32'd0);

      // Three wait states before every beat.
      wait_states = 3;
      push_line(1'b0, 1'b0, 32'h0000_1234);
      @(negedge CLK);
      start_req(1'b0, 1'b0, 32'h0000_1234);
      xfer_cnt = 0;
      wait_done(1'b0, c);
      check_val("ws_xfer_cycles", 32'(xfer_cnt), 32'(LW * 4));
      check_val("sb_drained_ws", 32'(exp_q.size()), 32'd0);
      wait_states = 0;

      // Reset during beat 2.
      push_line(1'b0, 1'b0, 32'h0000_6000);
      @(negedge CLK);
      start_req(1'b0, 1'b0, 32'h0000_6000);
      ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge CLK);
         if (bus.ic_beat == LB'(2)) ok = 1'b1;
      end
      check_val("reached_beat2", 32'(ok), 32'd1);
      #1;
      RESET      = 1'b0;
      bus.ic_req = 1'b0;
      #1;
      check_val("mid_rst_mem_req", 32'(bus.mem_req), 32'd0);
      check_val("mid_rst_ic_busy", 32'(bus.ic_busy), 32'd0);
      check_val("mid_rst_ic_beat", 32'(bus.ic_beat), 32'd0);
      exp_q.delete();
      any_done = 1'b0;
      repeat (3) begin
         @(negedge CLK);
         any_done = any_done | bus.ic_done;
      end
      RESET = 1'b1;
      repeat (2) begin
         @(negedge CLK);
         any_done = any_done | bus.ic_done;
      end
      check_val("no_done_after_rst", 32'(any_done), 32'd0);
      push_line(1'b0, 1'b0, 32'h0000_7008);
      start_req(1'b0, 1'b0, 32'h0000_7008);
      wait_done(1'b0, c);
      check_val("post_rst_latency", 32'(c), 32'(LW + 1));

      // D request arriving mid I burst.
      push_line(1'b0, 1'b0, 32'h0000_8000);
      push_line(1'b1, 1'b0, 32'h0000_9010);
      @(negedge CLK);
      start_req(1'b0, 1'b0, 32'h0000_8000);
      repeat (2) @(negedge CLK);
      start_req(1'b1, 1'b0, 32'h0000_9010);
      ok       = 1'b1;
      any_done = 1'b0;
      for (int i = 0; i < 50 && !any_done; i++) begin
         @(negedge CLK);
         if (!bus.dc_busy) ok = 1'b0;
         if (bus.ic_done) begin
            any_done   = 1'b1;
            bus.ic_req = 1'b0;
         end
      end
      check_val("late_d_ic_done", 32'(any_done), 32'd1);
      check_val("dc_busy_while_waiting", 32'(ok), 32'd1);
      @(negedge CLK);
      check_val("idle_gap_mem_req", 32'(bus.mem_req), 32'd0);
      check_val("idle_gap_dc_busy", 32'(bus.dc_busy), 32'd1);
      wait_done(1'b1, c);
      check_val("d_after_i_latency", 32'(c), 32'(LW + 1));
      check_val("sb_drained_late", 32'(exp_q.size()), 32'd0);

      repeat (2) @(negedge CLK);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
